// File: rtl/hci_tcdm_prio_ctrl_pkg.sv
// rtl/hci_tcdm_prio_ctrl_pkg.sv - shared types and default widths for the TCDM priority controller
package hci_tcdm_prio_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HWPE_PRIO = 2'd1,
    CORE_PRIO = 2'd2
  } prio_state_e;

  localparam int unsigned DEF_NB_CORES = 8;
  localparam int unsigned DEF_STALL_W  = 8;
  localparam int unsigned DEF_WIN_W    = 8;
  localparam int unsigned DEF_STAT_W   = 16;

endpackage

// File: rtl/hci_stall_counter.sv
// rtl/hci_stall_counter.sv - saturating consecutive-stall counter with threshold hit detect
module hci_stall_counter
  import hci_tcdm_prio_ctrl_pkg::*;
#(
  parameter int unsigned STALL_W = DEF_STALL_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               stall,
  input  logic               clr,
  input  logic [STALL_W-1:0] thr,
  output logic               hit,
  output logic [STALL_W-1:0] cnt
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clr || !stall) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + STALL_W'(1);
    end
  end

  // Equality compare: a threshold lowered below cnt waits for the run to restart.
  assign hit = (thr != '0) && stall && (cnt == thr - STALL_W'(1));

endmodule

// File: rtl/hci_tcdm_prio_ctrl.sv
// rtl/hci_tcdm_prio_ctrl.sv - hands TCDM priority to starving cores for a bounded window
module hci_tcdm_prio_ctrl
  import hci_tcdm_prio_ctrl_pkg::*;
#(
  parameter int unsigned NB_CORES = DEF_NB_CORES,
  parameter int unsigned STALL_W  = DEF_STALL_W,
  parameter int unsigned WIN_W    = DEF_WIN_W,
  parameter int unsigned STAT_W   = DEF_STAT_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                enable_i,
  input  logic [STALL_W-1:0]  cfg_max_stall_i,
  input  logic [WIN_W-1:0]    cfg_core_win_i,
  input  logic [NB_CORES-1:0] core_req_i,
  input  logic [NB_CORES-1:0] core_gnt_i,
  input  logic                hwpe_req_i,
  input  logic                hwpe_gnt_i,
  output logic                invert_prio_o,
  output logic [STALL_W-1:0]  low_prio_max_stall_o,
  output logic                starve_evt_o,
  output logic [STAT_W-1:0]   stat_switch_cnt_o,
  output logic [1:0]          state_o
);

  prio_state_e        state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               invert_q, evt_q;
  logic [STALL_W-1:0] max_stall_q;
  logic [STAT_W-1:0]  stat_q;

  logic               core_stall, core_pend, hwpe_stall, active;
  logic               cstall_clr, hstall_clr, cstall_hit, hstall_hit, go_core;
  logic [STALL_W-1:0] cstall_cnt, hstall_cnt;
  logic               unused_cnt;

  assign core_stall = |(core_req_i & ~core_gnt_i);
  assign core_pend  = |core_req_i;
  assign hwpe_stall = hwpe_req_i & ~hwpe_gnt_i;
  assign active     = enable_i & ~clear_i;
  assign unused_cnt = ^{cstall_cnt, hstall_cnt};

  hci_stall_counter #(.STALL_W(STALL_W)) i_core_stall (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .stall  (core_stall),
    .clr    (cstall_clr),
    .thr    (cfg_max_stall_i),
    .hit    (cstall_hit),
    .cnt    (cstall_cnt)
  );

  hci_stall_counter #(.STALL_W(STALL_W)) i_hwpe_stall (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .stall  (hwpe_stall),
    .clr    (hstall_clr),
    .thr    (cfg_max_stall_i),
    .hit    (hstall_hit),
    .cnt    (hstall_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Each stall counter only runs in the state that watches it; otherwise held at 0.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    go_core    = 1'b0;
    cstall_clr = 1'b1;
    hstall_clr = 1'b1;
    if (!active) begin
      state_d = IDLE;
      win_d   = '0;
    end else begin
      case (state_q)
        HWPE_PRIO: begin
          cstall_clr = 1'b0;
          if (cstall_hit) begin
            state_d    = CORE_PRIO;
            win_d      = (cfg_core_win_i == '0) ? '0 : cfg_core_win_i - WIN_W'(1);
            go_core    = 1'b1;
            cstall_clr = 1'b1;
          end
        end
        CORE_PRIO: begin
          hstall_clr = 1'b0;
          win_d      = win_q - WIN_W'(1);
          if ((win_q == '0) || !core_pend || hstall_hit) begin
            state_d    = HWPE_PRIO;
            win_d      = '0;
            hstall_clr = 1'b1;
          end
        end
        default: state_d = HWPE_PRIO;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q       <= '0;
      invert_q    <= 1'b0;
      evt_q       <= 1'b0;
      max_stall_q <= '0;
      stat_q      <= '0;
    end else begin
      win_q       <= win_d;
      invert_q    <= (state_d == CORE_PRIO);
      evt_q       <= go_core;
      max_stall_q <= active ? cfg_max_stall_i : '0;
      if (go_core && (stat_q != '1)) begin
        stat_q <= stat_q + STAT_W'(1);
      end
    end
  end

  assign invert_prio_o        = invert_q;
  assign low_prio_max_stall_o = max_stall_q;
  assign starve_evt_o         = evt_q;
  assign stat_switch_cnt_o    = stat_q;
  assign state_o              = state_q;

endmodule

// File: tb/tb_hci_tcdm_prio_ctrl.sv
// tb/tb_hci_tcdm_prio_ctrl.sv - scoreboard bench for hci_tcdm_prio_ctrl against a run-length model
module tb_hci_tcdm_prio_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] max_stall = '0;
  logic [7:0] core_win = '0;
  logic [7:0] core_req = '0;
  logic [7:0] core_gnt = '0;
  logic       hwpe_req = 1'b0;
  logic       hwpe_gnt = 1'b0;

  logic        invert;
  logic [7:0]  lp_stall;
  logic        evt;
  logic [15:0] stat;
  logic [1:0]  state;

  always #5 clk = ~clk;

  hci_tcdm_prio_ctrl dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .clear_i              (clear),
    .enable_i             (enable),
    .cfg_max_stall_i      (max_stall),
    .cfg_core_win_i       (core_win),
    .core_req_i           (core_req),
    .core_gnt_i           (core_gnt),
    .hwpe_req_i           (hwpe_req),
    .hwpe_gnt_i           (hwpe_gnt),
    .invert_prio_o        (invert),
    .low_prio_max_stall_o (lp_stall),
    .starve_evt_o         (evt),
    .stat_switch_cnt_o    (stat),
    .state_o              (state)
  );

  typedef struct {
    int st;
    int inv;
    int lps;
    int ev;
    int stat;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   checks = 0;
  int   passed = 0;

  // Model: mode 0 idle, 1 HWPE owns priority, 2 cores own priority.
  int m_mode = 0, m_crun = 0, m_hrun = 0, m_used = 0, m_budget = 0;
  int m_stat = 0, m_lps = 0, m_evt = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, expv, $time);
  endtask

  task automatic model_step();
    bit cst, cpend, hst;
    int thr;
    exp_t x;
    cst   = |(core_req & ~core_gnt);
    cpend = |core_req;
    hst   = hwpe_req & ~hwpe_gnt;
    thr   = int'(max_stall);
    m_evt = 0;
    if (!rst_n) begin
      m_mode = 0; m_crun = 0; m_hrun = 0; m_used = 0; m_stat = 0; m_lps = 0;
    end else if (clear || !enable) begin
      m_mode = 0; m_crun = 0; m_hrun = 0; m_used = 0; m_lps = 0;
    end else begin
      m_lps = thr;
      if (m_mode == 1) begin
        if (cst && thr != 0 && m_crun + 1 == thr) begin
          m_mode   = 2;
          m_crun   = 0;
          m_hrun   = 0;
          m_used   = 0;
          m_budget = (core_win == 0) ? 1 : int'(core_win);
          m_evt    = 1;
          if (m_stat < 65535) m_stat++;
        end else begin
          m_crun = cst ? m_crun + 1 : 0;
        end
      end else if (m_mode == 2) begin
        m_used++;
        if (m_used == m_budget || !cpend || (hst && thr != 0 && m_hrun + 1 == thr)) begin
          m_mode = 1;
          m_hrun = 0;
          m_crun = 0;
        end else begin
          m_hrun = hst ? m_hrun + 1 : 0;
        end
      end else begin
        m_mode = 1;
      end
    end
    x.st   = m_mode;
    x.inv  = (m_mode == 2) ? 1 : 0;
    x.lps  = m_lps;
    x.ev   = m_evt;
    x.stat = m_stat;
    expq.push_back(x);
  endtask

  task automatic drive(input int r, input int en, input int clr, input int thr, input int win,
                       input int creq, input int cgnt, input int hr, input int hg);
    @(negedge clk);
    rst_n     = r[0];
    enable    = en[0];
    clear     = clr[0];
    max_stall = thr[7:0];
    core_win  = win[7:0];
    core_req  = creq[7:0];
    core_gnt  = cgnt[7:0];
    hwpe_req  = hr[0];
    hwpe_gnt  = hg[0];
    model_step();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_step();
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("state", int'(state), e.st);
        chk("invert_prio", int'(invert), e.inv);
        chk("low_prio_max_stall", int'(lp_stall), e.lps);
        chk("starve_evt", int'(evt), e.ev);
        chk("stat_switch_cnt", int'(stat), e.stat);
      end
    end
  end

  initial begin
    int thr_r, win_r, creq_r, cgnt_r;
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) drive(1, 1, 0, 4, 10, 0, 0, 0, 0);
    // continuous core starvation: switch, full window, switch again
    repeat (30) drive(1, 1, 0, 4, 10, 'h01, 'h00, 0, 0);
    repeat (2) drive(1, 1, 0, 4, 10, 0, 0, 0, 0);
    // cores stop requesting three cycles into the window
    repeat (7) drive(1, 1, 0, 4, 10, 'h01, 'h00, 0, 0);
    repeat (3) drive(1, 1, 0, 4, 10, 0, 0, 0, 0);
    // HWPE starvation ends a long window early
    repeat (6) drive(1, 1, 0, 4, 50, 'h03, 'h01, 0, 0);
    repeat (6) drive(1, 1, 0, 4, 50, 'h03, 'h01, 1, 0);
    repeat (4) drive(1, 1, 0, 4, 50, 0, 0, 0, 0);
    // threshold 0 disables; 3-on/1-off never reaches 4
    repeat (100) drive(1, 1, 0, 0, 10, 'hff, 'h00, 0, 0);
    repeat (10) begin
      repeat (3) drive(1, 1, 0, 4, 10, 'h80, 'h00, 0, 0);
      drive(1, 1, 0, 4, 10, 'h80, 'h80, 0, 0);
    end
    // enable dropped mid-window, then soft clear mid-window, then async reset
    repeat (7) drive(1, 1, 0, 3, 20, 'h01, 'h00, 0, 0);
    repeat (2) drive(1, 0, 0, 3, 20, 'h01, 'h00, 0, 0);
    repeat (7) drive(1, 1, 0, 3, 20, 'h01, 'h00, 0, 0);
    drive(1, 1, 1, 3, 20, 'h01, 'h00, 0, 0);
    repeat (8) drive(1, 1, 0, 3, 20, 'h01, 'h00, 0, 0);
    async_reset();
    repeat (2) drive(0, 1, 0, 3, 20, 'h01, 'h00, 0, 0);
    repeat (4) drive(1, 1, 0, 3, 20, 'h01, 'h00, 0, 0);
    // randomized traffic with occasional config changes, disables and clears
    thr_r = 3;
    win_r = 5;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) thr_r = int'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) win_r = int'($urandom_range(0, 8));
      creq_r = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 255));
      cgnt_r = ($urandom_range(0, 2) == 0) ? creq_r : (int'($urandom_range(0, 255)) & creq_r);
      drive(1, ($urandom_range(0, 59) == 0) ? 0 : 1, ($urandom_range(0, 79) == 0) ? 1 : 0,
            thr_r, win_r, creq_r, cgnt_r,
            int'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 1 : 0);
    end
    @(posedge clk);
    #3;
    chk("scoreboard_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
